// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
//
// Sequencing controller for the UART transmit path.  Accepts a parallel word
// from the TX data source, captures it together with the parity configuration,
// and steps the bit serializer through START, DATA, optional PARITY and STOP.
// Chooses the bit on the TX line, supplies the parity bit and reports BUSY.
//
// Optional feature macro: UART_TX_BACK_TO_BACK_EN
//   defined   : DATA_VALID seen in STOP is accepted and the next frame starts
//               immediately (gapless frames, BUSY stays high).
//   undefined : STOP always returns to IDLE; DATA_VALID in STOP is ignored.
//
// Ports
//   CLK        in   TX bit clock, one bit period per cycle
//   RST        in   asynchronous reset, active-low
//   P_DATA     in   word to transmit, sampled on acceptance
//   DATA_VALID in   request to send P_DATA
//   PAR_EN     in   parity bit enable, sampled on acceptance
//   PAR_TYP    in   parity type (0 even, 1 odd), sampled on acceptance
//   ser_done   in   serializer is presenting its last data bit
//   ser_data   in   current serializer bit
//   ser_en     out  serializer shift enable (DATA state only)
//   ser_load   out  one-cycle pulse, serializer captures ser_pdata
//   ser_pdata  out  held copy of the accepted word
//   TX_OUT     out  serial line
//   BUSY       out  frame in progress
//   FRAME_ERR  out  sticky, serializer never signalled the end of the data phase
// -----------------------------------------------------------------------------
module uart_tx_controller #(
   parameter int WIDTH_DATA = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WIDTH_DATA-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_done,
   input  logic                  ser_data,
   output logic                  ser_en,
   output logic                  ser_load,
   output logic [WIDTH_DATA-1:0] ser_pdata,
   output logic                  TX_OUT,
   output logic                  BUSY,
   output logic                  FRAME_ERR
);

   localparam int CNT_W = $clog2(WIDTH_DATA + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [WIDTH_DATA-1:0] pdata_q,   pdata_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  xor_q,     xor_d;
   logic                  load_q,    load_d;
   logic                  ferr_q,    ferr_d;
   logic                  accept;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pdata_q   <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         xor_q     <= 1'b0;
         load_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pdata_q   <= pdata_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         xor_q     <= xor_d;
         load_q    <= load_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pdata_d   = pdata_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      xor_d     = xor_q;
      load_d    = 1'b0;
      ferr_d    = ferr_q;
      accept    = 1'b0;

      ser_en    = 1'b0;
      TX_OUT    = 1'b1;

      case (state_q)
         IDLE: begin
            accept = DATA_VALID;
         end
         START: begin
            TX_OUT  = 1'b0;
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            ser_en = 1'b1;
            TX_OUT = ser_data;
            cnt_d  = cnt_q + 1'b1;
            if (ser_done) begin
               state_d = par_en_q ? PARITY : STOP;
            end else if (cnt_q == CNT_W'(WIDTH_DATA - 1)) begin
               // Last permitted data cycle without ser_done: abandon parity.
               ferr_d  = 1'b1;
               state_d = STOP;
            end
         end
         PARITY: begin
            // Stored XOR of the word, inverted for odd parity.
            TX_OUT  = xor_q ^ par_typ_q;
            state_d = STOP;
         end
         STOP: begin
            TX_OUT  = 1'b1;
            state_d = IDLE;
`ifdef UART_TX_BACK_TO_BACK_EN
            accept  = DATA_VALID;
`else
            accept  = 1'b0;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Acceptance overrides the per-state next state (IDLE or STOP).
      if (accept) begin
         state_d   = START;
         pdata_d   = P_DATA;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
         xor_d     = ^P_DATA;
         load_d    = 1'b1;
         ferr_d    = 1'b0;
      end
   end

   // ser_load is registered so it coincides with the freshly captured
   // ser_pdata in the START cycle, before the first DATA shift.
   assign ser_load  = load_q;
   assign ser_pdata = pdata_q;
   assign BUSY      = (state_q != IDLE);
   assign FRAME_ERR = ferr_q;

endmodule
